// File: rtl/fcl_bin_pkg.sv
// ---------------------------------------------------------------------------
// fcl_bin_pkg
// Shared definitions for the binary fully-connected layer controller:
// default array/memory dimensions, the widths derived from them, and the
// controller state encoding.
// ---------------------------------------------------------------------------
package fcl_bin_pkg;

    // Default dimensions of the layer engine
    localparam int BIN_PARALLEL_DEF = 16;
    localparam int ACC_WIDTH_DEF    = 16;
    localparam int IN_LEN_MAX_DEF   = 1024;
    localparam int GRP_MAX_DEF      = 64;

    // Widths derived from the default dimensions
    localparam int LEN_W   = $clog2(IN_LEN_MAX_DEF + 1);             // in_len
    localparam int GCNT_W  = $clog2(GRP_MAX_DEF + 1);                // num_groups
    localparam int SHIFT_W = $clog2(ACC_WIDTH_DEF);                  // shift_cfg
    localparam int IN_AW   = $clog2(IN_LEN_MAX_DEF);                 // in_addr
    localparam int GIDX_W  = $clog2(GRP_MAX_DEF);                    // out_group
    localparam int W_AW    = $clog2(IN_LEN_MAX_DEF * GRP_MAX_DEF);   // w_addr

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ACC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/fcl_bin_ctrl_if.sv
// ---------------------------------------------------------------------------
// fcl_bin_ctrl_if
// Bundles every non-clock/reset signal of the controller.
//   master : controller side (fcl_bin_ctrl)
//   slave  : environment side (layer launcher, input/weight memories,
//            PE array, result consumer)
// Signals: start/in_len/num_groups/shift_cfg/busy/done (layer control),
//          in_addr/in_bit, w_addr/w_word (memory reads, 1-cycle latency),
//          pe_rst/pe_in/pe_w/pe_shift/pe_out (PE array),
//          out_valid/out_ready/out_data/out_group (result handshake).
// ---------------------------------------------------------------------------
interface fcl_bin_ctrl_if
    import fcl_bin_pkg::*;
#(
    parameter int BIN_PARALLEL = BIN_PARALLEL_DEF,
    parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
    parameter int IN_LEN_MAX   = IN_LEN_MAX_DEF,
    parameter int GRP_MAX      = GRP_MAX_DEF
);
    localparam int L_W  = $clog2(IN_LEN_MAX + 1);
    localparam int GC_W = $clog2(GRP_MAX + 1);
    localparam int SH_W = $clog2(ACC_WIDTH);
    localparam int IA_W = $clog2(IN_LEN_MAX);
    localparam int GI_W = $clog2(GRP_MAX);
    localparam int WA_W = $clog2(IN_LEN_MAX * GRP_MAX);

    logic                    start;
    logic [L_W-1:0]          in_len;
    logic [GC_W-1:0]         num_groups;
    logic [SH_W-1:0]         shift_cfg;
    logic                    busy;
    logic                    done;
    logic [IA_W-1:0]         in_addr;
    logic                    in_bit;
    logic [WA_W-1:0]         w_addr;
    logic [BIN_PARALLEL-1:0] w_word;
    logic                    pe_rst;
    logic                    pe_in;
    logic [BIN_PARALLEL-1:0] pe_w;
    logic [SH_W-1:0]         pe_shift;
    logic [BIN_PARALLEL-1:0] pe_out;
    logic                    out_valid;
    logic                    out_ready;
    logic [BIN_PARALLEL-1:0] out_data;
    logic [GI_W-1:0]         out_group;

    modport master (
        input  start, in_len, num_groups, shift_cfg, in_bit, w_word, pe_out, out_ready,
        output busy, done, in_addr, w_addr, pe_rst, pe_in, pe_w, pe_shift,
               out_valid, out_data, out_group
    );

    modport slave (
        output start, in_len, num_groups, shift_cfg, in_bit, w_word, pe_out, out_ready,
        input  busy, done, in_addr, w_addr, pe_rst, pe_in, pe_w, pe_shift,
               out_valid, out_data, out_group
    );

endinterface

// File: rtl/fcl_bin_agen.sv
// ---------------------------------------------------------------------------
// fcl_bin_agen
// Address and element counters of the layer controller.
//   clk, rst       : clock, synchronous active-low reset
//   clr_i          : return all counters to zero
//   launch_i       : first group of a layer (all counters zero)
//   addr_step_i    : prefetch the next element address if one remains
//   elem_step_i    : advance the accumulate-cycle index
//   next_grp_i     : move to the next group
//   len_i, grps_i  : latched vector length N and group count G
//   in_addr_o      : input bit address (restarts at 0 each group)
//   w_addr_o       : weight address, g*N+k from a running counter
//   elem_o, grp_o  : current element index k and group index g
//   last_elem_o    : k == N-1
//   last_grp_o     : g == G-1
// ---------------------------------------------------------------------------
module fcl_bin_agen
    import fcl_bin_pkg::*;
#(
    parameter int IN_LEN_MAX = IN_LEN_MAX_DEF,
    parameter int GRP_MAX    = GRP_MAX_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clr_i,
    input  logic                                 launch_i,
    input  logic                                 addr_step_i,
    input  logic                                 elem_step_i,
    input  logic                                 next_grp_i,
    input  logic [$clog2(IN_LEN_MAX+1)-1:0]      len_i,
    input  logic [$clog2(GRP_MAX+1)-1:0]         grps_i,
    output logic [$clog2(IN_LEN_MAX)-1:0]        in_addr_o,
    output logic [$clog2(IN_LEN_MAX*GRP_MAX)-1:0] w_addr_o,
    output logic [$clog2(IN_LEN_MAX)-1:0]        elem_o,
    output logic [$clog2(GRP_MAX)-1:0]           grp_o,
    output logic                                 last_elem_o,
    output logic                                 last_grp_o
);
    localparam int L_W  = $clog2(IN_LEN_MAX + 1);
    localparam int GC_W = $clog2(GRP_MAX + 1);
    localparam int IA_W = $clog2(IN_LEN_MAX);
    localparam int GI_W = $clog2(GRP_MAX);
    localparam int WA_W = $clog2(IN_LEN_MAX * GRP_MAX);

    logic [IA_W-1:0] in_addr_q, in_addr_d;
    logic [WA_W-1:0] w_addr_q,  w_addr_d;
    logic [IA_W-1:0] elem_q,    elem_d;
    logic [GI_W-1:0] grp_q,     grp_d;
    logic            more_s;

    // Another element remains to be prefetched in this group
    assign more_s      = (L_W'(in_addr_q) + L_W'(1'b1)) < len_i;
    assign last_elem_o = (L_W'(elem_q) + L_W'(1'b1)) == len_i;
    assign last_grp_o  = (GC_W'(grp_q) + GC_W'(1'b1)) == grps_i;

    // Next-state of the counters; weight address runs on across groups
    always_comb begin
        in_addr_d = in_addr_q;
        w_addr_d  = w_addr_q;
        elem_d    = elem_q;
        grp_d     = grp_q;
        if (clr_i || launch_i) begin
            in_addr_d = '0;
            w_addr_d  = '0;
            elem_d    = '0;
            grp_d     = '0;
        end else if (next_grp_i) begin
            // last address of group g was g*N+N-1, so +1 is the next base
            in_addr_d = '0;
            w_addr_d  = w_addr_q + WA_W'(1'b1);
            elem_d    = '0;
            grp_d     = grp_q + GI_W'(1'b1);
        end else begin
            if (addr_step_i && more_s) begin
                in_addr_d = in_addr_q + IA_W'(1'b1);
                w_addr_d  = w_addr_q + WA_W'(1'b1);
            end else begin
                in_addr_d = in_addr_q;
                w_addr_d  = w_addr_q;
            end
            if (elem_step_i) begin
                elem_d = elem_q + IA_W'(1'b1);
            end else begin
                elem_d = elem_q;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_addr_q <= '0;
            w_addr_q  <= '0;
            elem_q    <= '0;
            grp_q     <= '0;
        end else begin
            in_addr_q <= in_addr_d;
            w_addr_q  <= w_addr_d;
            elem_q    <= elem_d;
            grp_q     <= grp_d;
        end
    end

    assign in_addr_o = in_addr_q;
    assign w_addr_o  = w_addr_q;
    assign elem_o    = elem_q;
    assign grp_o     = grp_q;

endmodule

// File: rtl/fcl_bin_ctrl.sv
// ---------------------------------------------------------------------------
// fcl_bin_ctrl
// Sequencer for a binary fully-connected layer computed on an external
// array of BIN_PARALLEL XNOR/popcount PEs. For each of G output groups it
// streams the N input bits and matching weight words into the array, lets
// the array accumulate, captures the array outputs and offers them on a
// valid/ready handshake.
//   clk, rst : clock, synchronous active-low reset
//   bus      : fcl_bin_ctrl_if master modport (control, memories, PE array,
//              result handshake)
// ---------------------------------------------------------------------------
module fcl_bin_ctrl
    import fcl_bin_pkg::*;
#(
    parameter int BIN_PARALLEL = BIN_PARALLEL_DEF,
    parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
    parameter int IN_LEN_MAX   = IN_LEN_MAX_DEF,
    parameter int GRP_MAX      = GRP_MAX_DEF
) (
    input  logic           clk,
    input  logic           rst,
    fcl_bin_ctrl_if.master bus
);
    localparam int L_W  = $clog2(IN_LEN_MAX + 1);
    localparam int GC_W = $clog2(GRP_MAX + 1);
    localparam int SH_W = $clog2(ACC_WIDTH);
    localparam int IA_W = $clog2(IN_LEN_MAX);
    localparam int GI_W = $clog2(GRP_MAX);
    localparam int WA_W = $clog2(IN_LEN_MAX * GRP_MAX);

    state_e                  state_q, state_d;
    logic [L_W-1:0]          len_q;
    logic [GC_W-1:0]         grps_q;
    logic [SH_W-1:0]         shift_q;
    logic [BIN_PARALLEL-1:0] out_data_q;

    logic            cfg_ok_s;
    logic            launch_s;
    logic            clr_s;
    logic            addr_step_s;
    logic            elem_step_s;
    logic            next_grp_s;
    logic            last_elem_s;
    logic            last_grp_s;
    logic [IA_W-1:0] in_addr_s;
    logic [WA_W-1:0] w_addr_s;
    logic [IA_W-1:0] elem_s;
    logic [GI_W-1:0] grp_s;

    // An empty vector or zero groups finishes immediately
    assign cfg_ok_s = (bus.in_len != '0) && (bus.num_groups != '0);

    // Next-state and counter strobes
    always_comb begin
        state_d     = state_q;
        launch_s    = 1'b0;
        clr_s       = 1'b0;
        addr_step_s = 1'b0;
        elem_step_s = 1'b0;
        next_grp_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (cfg_ok_s) begin
                        launch_s = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                addr_step_s = 1'b1;
                state_d     = ST_ACC;
            end
            ST_ACC: begin
                addr_step_s = 1'b1;
                if (last_elem_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    elem_step_s = 1'b1;
                    state_d     = ST_ACC;
                end
            end
            ST_DRAIN: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    if (last_grp_s) begin
                        state_d = ST_DONE;
                    end else begin
                        next_grp_s = 1'b1;
                        state_d    = ST_FETCH;
                    end
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_DONE: begin
                clr_s   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                clr_s   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Layer configuration is captured only on a valid launch from IDLE
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_q   <= '0;
            grps_q  <= '0;
            shift_q <= '0;
        end else if (launch_s) begin
            len_q   <= bus.in_len;
            grps_q  <= bus.num_groups;
            shift_q <= bus.shift_cfg;
        end else begin
            len_q   <= len_q;
            grps_q  <= grps_q;
            shift_q <= shift_q;
        end
    end

    // Result capture at the end of DRAIN, once the last accumulation landed
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_data_q <= '0;
        end else if (state_q == ST_DRAIN) begin
            out_data_q <= bus.pe_out;
        end else begin
            out_data_q <= out_data_q;
        end
    end

    fcl_bin_agen #(
        .IN_LEN_MAX (IN_LEN_MAX),
        .GRP_MAX    (GRP_MAX)
    ) u_agen (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr_s),
        .launch_i    (launch_s),
        .addr_step_i (addr_step_s),
        .elem_step_i (elem_step_s),
        .next_grp_i  (next_grp_s),
        .len_i       (len_q),
        .grps_i      (grps_q),
        .in_addr_o   (in_addr_s),
        .w_addr_o    (w_addr_s),
        .elem_o      (elem_s),
        .grp_o       (grp_s),
        .last_elem_o (last_elem_s),
        .last_grp_o  (last_grp_s)
    );

    assign bus.busy      = (state_q == ST_FETCH) || (state_q == ST_ACC) ||
                           (state_q == ST_DRAIN) || (state_q == ST_OUT);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.out_valid = (state_q == ST_OUT);
    assign bus.out_data  = out_data_q;
    assign bus.out_group = grp_s;
    assign bus.in_addr   = in_addr_s;
    assign bus.w_addr    = w_addr_s;
    assign bus.pe_shift  = shift_q;

    // The array loads on pe_rst=0 and accumulates on pe_rst=1 every cycle,
    // so only ACC cycles after the first may accumulate. Memory data arrives
    // one cycle after its address, which lines up with the ACC cycle.
    assign bus.pe_rst = (state_q == ST_ACC) && (elem_s != '0);
    assign bus.pe_in  = (state_q == ST_ACC) ? bus.in_bit : 1'b0;
    assign bus.pe_w   = (state_q == ST_ACC) ? bus.w_word : '0;

endmodule

// File: tb/tb_fcl_bin_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fcl_bin_ctrl
// Directed bench for fcl_bin_ctrl with input/weight memory models and a
// behavioural fcl_bin PE array (XNOR, accumulate, shifted non-zero test).
// ---------------------------------------------------------------------------
module tb_fcl_bin_ctrl;
    import fcl_bin_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fcl_bin_ctrl_if #(
        .BIN_PARALLEL (BIN_PARALLEL_DEF),
        .ACC_WIDTH    (ACC_WIDTH_DEF),
        .IN_LEN_MAX   (IN_LEN_MAX_DEF),
        .GRP_MAX      (GRP_MAX_DEF)
    ) bus ();

    fcl_bin_ctrl #(
        .BIN_PARALLEL (BIN_PARALLEL_DEF),
        .ACC_WIDTH    (ACC_WIDTH_DEF),
        .IN_LEN_MAX   (IN_LEN_MAX_DEF),
        .GRP_MAX      (GRP_MAX_DEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memories with one-cycle read latency
    logic        in_mem [0:15];
    logic [15:0] w_mem  [0:15];

    always_ff @(posedge clk) begin
        bus.in_bit <= in_mem[bus.in_addr[3:0]];
        bus.w_word <= w_mem[bus.w_addr[3:0]];
    end

    // PE array model: load on pe_rst=0, accumulate on pe_rst=1
    logic [15:0] pe_acc [0:15];
    logic [15:0] pe_out_s;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (!bus.pe_rst) begin
                pe_acc[i] <= {15'd0, ~(bus.pe_in ^ bus.pe_w[i])};
            end else begin
                pe_acc[i] <= pe_acc[i] + {15'd0, ~(bus.pe_in ^ bus.pe_w[i])};
            end
        end
    end

    always_comb begin
        pe_out_s = 16'd0;
        for (int i = 0; i < 16; i++) begin
            pe_out_s[i] = |(pe_acc[i] >> bus.pe_shift);
        end
    end

    assign bus.pe_out = pe_out_s;

    // Event counters sampled just after each edge
    int hs_cnt   = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (rst && bus.out_valid && bus.out_ready) hs_cnt++;
        if (bus.done) done_cnt++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive start for exactly one edge; returns in the cycle after it
    task automatic launch(input int n, input int g, input int sh);
        bus.in_len     = LEN_W'(n);
        bus.num_groups = GCNT_W'(g);
        bus.shift_cfg  = SHIFT_W'(sh);
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
    endtask

    task automatic load_a();
        in_mem[0] = 1'b1; in_mem[1] = 1'b0; in_mem[2] = 1'b1;
        w_mem[0] = 16'h00FF; w_mem[1] = 16'h0F0F; w_mem[2] = 16'h3333;
    endtask

    logic [15:0] drain_pe;
    int          hs0;
    int          done0;

    initial begin
        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.in_len     = '0;
        bus.num_groups = '0;
        bus.shift_cfg  = '0;
        bus.out_ready  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_mem[i] = 1'b0;
            w_mem[i]  = 16'h0000;
        end
        repeat (2) @(negedge clk);

        // ---- reset state
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_done",      32'(bus.done),      32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_pe_rst",    32'(bus.pe_rst),    32'd0);
        chk("rst_in_addr",   32'(bus.in_addr),   32'd0);
        chk("rst_w_addr",    32'(bus.w_addr),    32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        rst = 1'b1;
        @(negedge clk);

        // ---- N=3, G=1, shift 1: majority(00FF, ~0F0F, 3333) = 30F3
        load_a();
        hs0 = hs_cnt; done0 = done_cnt;
        launch(3, 1, 1);
        chk("A_fetch_busy",  32'(bus.busy),     32'd1);
        chk("A_fetch_in",    32'(bus.in_addr),  32'd0);
        chk("A_fetch_w",     32'(bus.w_addr),   32'd0);
        chk("A_fetch_perst", 32'(bus.pe_rst),   32'd0);
        chk("A_pe_shift",    32'(bus.pe_shift), 32'd1);
        @(negedge clk);
        chk("A_k0_perst", 32'(bus.pe_rst),  32'd0);
        chk("A_k0_in",    32'(bus.in_addr), 32'd1);
        chk("A_k0_pein",  32'(bus.pe_in),   32'd1);
        chk("A_k0_pew",   32'(bus.pe_w),    32'h00FF);
        @(negedge clk);
        chk("A_k1_perst", 32'(bus.pe_rst),  32'd1);
        chk("A_k1_in",    32'(bus.in_addr), 32'd2);
        chk("A_k1_pein",  32'(bus.pe_in),   32'd0);
        chk("A_k1_pew",   32'(bus.pe_w),    32'h0F0F);
        @(negedge clk);
        chk("A_k2_perst", 32'(bus.pe_rst),  32'd1);
        chk("A_k2_pein",  32'(bus.pe_in),   32'd1);
        chk("A_k2_pew",   32'(bus.pe_w),    32'h3333);
        @(negedge clk);
        chk("A_drain_perst", 32'(bus.pe_rst),    32'd0);
        chk("A_drain_valid", 32'(bus.out_valid), 32'd0);
        drain_pe = bus.pe_out;
        chk("A_drain_pe",    32'(drain_pe),      32'h30F3);
        @(negedge clk);
        chk("A_out_valid", 32'(bus.out_valid), 32'd1);
        chk("A_out_data",  32'(bus.out_data),  32'h30F3);
        chk("A_out_vs_pe", 32'(bus.out_data),  32'(drain_pe));
        chk("A_out_group", 32'(bus.out_group), 32'd0);
        @(negedge clk);
        chk("A_done",       32'(bus.done),      32'd1);
        chk("A_done_busy",  32'(bus.busy),      32'd0);
        chk("A_done_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("A_done_low", 32'(bus.done),        32'd0);
        chk("A_n_done",   32'(done_cnt - done0), 32'd1);
        chk("A_n_hs",     32'(hs_cnt - hs0),     32'd1);

        // ---- N=4, G=3: contiguous weights, in_addr restarts per group
        in_mem[0] = 1'b1; in_mem[1] = 1'b1; in_mem[2] = 1'b0; in_mem[3] = 1'b0;
        for (int i = 0; i < 12; i++) w_mem[i] = 16'(i * 4951 + 1234);
        hs0 = hs_cnt; done0 = done_cnt;
        launch(4, 3, 2);
        for (int g = 0; g < 3; g++) begin
            chk("B_fetch_in",    32'(bus.in_addr),   32'd0);
            chk("B_fetch_w",     32'(bus.w_addr),    32'(4 * g));
            chk("B_fetch_valid", 32'(bus.out_valid), 32'd0);
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                chk("B_acc_in", 32'(bus.in_addr), 32'(j + 1));
                chk("B_acc_w",  32'(bus.w_addr),  32'(4 * g + j + 1));
            end
            @(negedge clk);
            chk("B_k3_w",     32'(bus.w_addr), 32'(4 * g + 3));
            chk("B_k3_perst", 32'(bus.pe_rst), 32'd1);
            @(negedge clk);
            drain_pe = bus.pe_out;
            @(negedge clk);
            chk("B_out_valid", 32'(bus.out_valid), 32'd1);
            chk("B_out_group", 32'(bus.out_group), 32'(g));
            chk("B_out_data",  32'(bus.out_data),  32'(drain_pe));
            @(negedge clk);
        end
        chk("B_done", 32'(bus.done), 32'd1);
        @(negedge clk);
        chk("B_n_done", 32'(done_cnt - done0), 32'd1);
        chk("B_n_hs",   32'(hs_cnt - hs0),     32'd3);

        // ---- N=2, G=2 with out_ready low for 5 OUT cycles
        bus.out_ready = 1'b0;
        launch(2, 2, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        drain_pe = bus.pe_out;
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            chk("C_stall_valid", 32'(bus.out_valid), 32'd1);
            chk("C_stall_data",  32'(bus.out_data),  32'(drain_pe));
            chk("C_stall_group", 32'(bus.out_group), 32'd0);
            chk("C_stall_w",     32'(bus.w_addr),    32'd1);
            chk("C_stall_in",    32'(bus.in_addr),   32'd1);
            @(negedge clk);
        end
        chk("C_hold_valid", 32'(bus.out_valid), 32'd1);
        chk("C_hold_data",  32'(bus.out_data),  32'(drain_pe));
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("C_fetch_valid", 32'(bus.out_valid), 32'd0);
        chk("C_fetch_busy",  32'(bus.busy),      32'd1);
        chk("C_fetch_in",    32'(bus.in_addr),   32'd0);
        chk("C_fetch_w",     32'(bus.w_addr),    32'd2);
        chk("C_fetch_perst", 32'(bus.pe_rst),    32'd0);
        @(negedge clk);
        chk("C_k0_perst", 32'(bus.pe_rst), 32'd0);
        chk("C_k0_w",     32'(bus.w_addr), 32'd3);
        @(negedge clk);
        chk("C_k1_perst", 32'(bus.pe_rst), 32'd1);
        @(negedge clk);
        drain_pe = bus.pe_out;
        @(negedge clk);
        chk("C_out1_group", 32'(bus.out_group), 32'd1);
        chk("C_out1_data",  32'(bus.out_data),  32'(drain_pe));
        @(negedge clk);
        chk("C_done", 32'(bus.done), 32'd1);
        @(negedge clk);

        // ---- degenerate launches: N=0, then G=0
        hs0 = hs_cnt;
        launch(0, 1, 0);
        chk("D_n0_done",  32'(bus.done),      32'd1);
        chk("D_n0_busy",  32'(bus.busy),      32'd0);
        chk("D_n0_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("D_n0_done_low", 32'(bus.done),      32'd0);
        chk("D_n0_busy2",    32'(bus.busy),      32'd0);
        chk("D_n0_valid2",   32'(bus.out_valid), 32'd0);
        launch(2, 0, 0);
        chk("D_g0_done", 32'(bus.done), 32'd1);
        chk("D_g0_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("D_g0_busy2", 32'(bus.busy),   32'd0);
        chk("D_n_hs",     32'(hs_cnt - hs0), 32'd0);

        // ---- reset during ACC k=2, then a clean N=2, G=1 run
        hs0 = hs_cnt;
        launch(4, 1, 2);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("E_k2_perst", 32'(bus.pe_rst), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("E_rst_busy",   32'(bus.busy),      32'd0);
        chk("E_rst_done",   32'(bus.done),      32'd0);
        chk("E_rst_valid",  32'(bus.out_valid), 32'd0);
        chk("E_rst_perst",  32'(bus.pe_rst),    32'd0);
        chk("E_rst_pein",   32'(bus.pe_in),     32'd0);
        chk("E_rst_pew",    32'(bus.pe_w),      32'd0);
        chk("E_rst_shift",  32'(bus.pe_shift),  32'd0);
        chk("E_rst_in",     32'(bus.in_addr),   32'd0);
        chk("E_rst_w",      32'(bus.w_addr),    32'd0);
        chk("E_rst_data",   32'(bus.out_data),  32'd0);
        chk("E_rst_group",  32'(bus.out_group), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("E_idle_valid", 32'(bus.out_valid), 32'd0);
        chk("E_n_hs",       32'(hs_cnt - hs0),  32'd0);
        // match where w0=1 (bit 1) or w1=0 (bit 0): AAAA | FF00 = FFAA
        in_mem[0] = 1'b1; in_mem[1] = 1'b0;
        w_mem[0] = 16'hAAAA; w_mem[1] = 16'h00FF;
        launch(2, 1, 0);
        chk("E2_fetch_w",  32'(bus.w_addr),  32'd0);
        chk("E2_fetch_in", 32'(bus.in_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("E2_out_valid", 32'(bus.out_valid), 32'd1);
        chk("E2_out_data",  32'(bus.out_data),  32'hFFAA);
        @(negedge clk);
        chk("E2_done", 32'(bus.done), 32'd1);
        @(negedge clk);

        // ---- start and new configuration while busy are ignored
        load_a();
        hs0 = hs_cnt; done0 = done_cnt;
        launch(3, 1, 1);
        @(negedge clk);
        bus.in_len     = LEN_W'(1);
        bus.num_groups = GCNT_W'(5);
        bus.shift_cfg  = SHIFT_W'(3);
        bus.start      = 1'b1;
        @(negedge clk);
        chk("F_k1_in",    32'(bus.in_addr),  32'd2);
        chk("F_k1_shift", 32'(bus.pe_shift), 32'd1);
        chk("F_k1_perst", 32'(bus.pe_rst),   32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        chk("F_k2_w",     32'(bus.w_addr),   32'd2);
        chk("F_k2_busy",  32'(bus.busy),     32'd1);
        @(negedge clk);
        chk("F_drain_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk("F_out_valid", 32'(bus.out_valid), 32'd1);
        chk("F_out_data",  32'(bus.out_data),  32'h30F3);
        @(negedge clk);
        chk("F_done", 32'(bus.done), 32'd1);
        @(negedge clk);
        chk("F_idle_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("F_idle_busy2", 32'(bus.busy),       32'd0);
        chk("F_n_hs",       32'(hs_cnt - hs0),    32'd1);
        chk("F_n_done",     32'(done_cnt - done0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fcl_bin_ctrl.md
FCL_BIN_CTRL -- requirements
Module: fcl_bin_ctrl

Interface
REQ-001 Parameter BIN_PARALLEL, default 16: PE count, which is the output bits per group.
REQ-002 Parameter ACC_WIDTH, default 16: PE accumulator width.
REQ-003 Parameter IN_LEN_MAX, default 1024: maximum input vector length.
REQ-004 Parameter GRP_MAX, default 64: maximum output groups.
REQ-005 clk  in  1  sole clock; all logic on posedge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 start  in  1  launch a layer; sampled only in IDLE.
REQ-008 in_len  in  $clog2(IN_LEN_MAX+1)  input vector length N.
REQ-009 num_groups  in  $clog2(GRP_MAX+1)  output group count G.
REQ-010 shift_cfg  in  $clog2(ACC_WIDTH)  PE output shift.
REQ-011 busy  out  1  high from FETCH through OUT.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 in_addr  out  $clog2(IN_LEN_MAX)  input bit memory address.
REQ-014 in_bit  in  1  input memory data, valid 1 cycle after its address.
REQ-015 w_addr  out  $clog2(IN_LEN_MAX*GRP_MAX)  weight memory address.
REQ-016 w_word  in  BIN_PARALLEL  weight data, valid 1 cycle after its address.
REQ-017 pe_rst  out  1  active-low load/accumulate control to the PE array.
REQ-018 pe_in  out  1  input bit to the PE array.
REQ-019 pe_w  out  BIN_PARALLEL  weights to the PE array.
REQ-020 pe_shift  out  $clog2(ACC_WIDTH)  latched shift_cfg.
REQ-021 pe_out  in  BIN_PARALLEL  PE array outputs.
REQ-022 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-023 out_data  out  BIN_PARALLEL  captured group result.
REQ-024 out_group  out  $clog2(GRP_MAX)  index of the group in out_data.

Function
REQ-025 The FSM SHALL have states IDLE, FETCH, ACC, DRAIN, OUT and DONE.
REQ-026 In IDLE, start=1 with N>0 and G>0 SHALL latch N, G and shift_cfg, then go to FETCH.
REQ-027 In IDLE, start=1 with N=0 or G=0 SHALL go to DONE with no out_valid.
REQ-028 FETCH SHALL last 1 cycle: in_addr=0, w_addr=group base; then go to ACC.
REQ-029 ACC SHALL last exactly N cycles.
- In cycle k: pe_in=in_bit, pe_w=w_word, pe_rst=0 if k==0 else 1.
- In cycle k: issue in_addr=k+1 and w_addr=base+k+1 when k+1<N.
REQ-030 DRAIN SHALL last 1 cycle and register pe_out into out_data at its closing edge; the FSM then goes to OUT.
REQ-031 pe_rst SHALL be 0 in every state except ACC cycles k>=1, because the array accumulates every cycle.
REQ-032 OUT SHALL hold out_valid=1 until out_ready=1.
- While stalled: out_data, out_group and the addresses stay stable.
REQ-033 On the OUT handshake, the FSM SHALL go to FETCH for the next group, or to DONE if it was the last group.
REQ-034 DONE SHALL last 1 cycle: done=1, busy=0; then return to IDLE.
REQ-035 Weights SHALL be group-major contiguous: group g, element k at w_addr=g*N+k.
- Generated by an incrementing counter, not a multiplier.
REQ-036 in_addr SHALL restart at 0 for each group.
REQ-037 Cycle timing for start sampled at edge T:
- FETCH occupies cycle T+1.
- ACC occupies cycles T+2 .. T+1+N.
- DRAIN occupies cycle T+2+N.
- out_valid rises in cycle T+3+N.
REQ-038 start while busy SHALL be ignored; configuration inputs outside IDLE SHALL be ignored.

Reset
REQ-039 rst=0 at any edge SHALL force IDLE and zero every output, including pe_rst=0, out_valid=0 and done=0.
REQ-040 Reset mid-operation SHALL discard the partial group with no out_valid; the next start SHALL run cleanly.

Structure
REQ-041 Package fcl_bin_pkg SHALL hold the state enum and the width localparams derived from the parameters.
REQ-042 Address/element counters SHALL sit in one sub-module, fcl_bin_agen; the PE array is instantiated outside this block.

Verification
REQ-043 The bench SHALL connect an fcl_bin array model and cover:
- N=3, G=1, ready tied 1: pe_rst sequence 0,1,1; in_addr 0,1,2; out_valid at T+6; out_data equals pe_out sampled in DRAIN; done at T+7.
- N=4, G=3: w_addr 0..11 contiguous; in_addr 0..3 three times; out_group 0,1,2; exactly one done pulse.
- out_ready low 5 cycles in OUT: out_data, out_group and w_addr held; FETCH begins the cycle after the handshake.
- in_len=0 with start: done the next cycle; busy and out_valid never assert.
- rst low during ACC at k=2: next cycle IDLE, all outputs 0; a following N=2, G=1 run completes correctly.
- start pulsed while busy: no effect on counters, latched N or G, or output count.
